// File: rtl/bus_blitter.sv
// Rectangular word-copy bus master for the MIO bus: reads a source rectangle and writes it to a destination.
// Optional transparent-colour skipping is enabled with `define BLIT_COLORKEY_EN.
module bus_blitter #(
    parameter int DIM_W  = 10,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_base,
    input  logic [31:0]      dst_base,
    input  logic [DIM_W-1:0] blk_w,
    input  logic [DIM_W-1:0] blk_h,
    input  logic [15:0]      src_stride,
    input  logic [15:0]      dst_stride,
    input  logic [11:0]      key_color,
    input  logic             bus_grant,
    input  logic             bus_ready,
    input  logic [31:0]      bus_rdata,
    output logic             bus_req,
    output logic [31:0]      bus_addr,
    output logic [31:0]      bus_wdata,
    output logic             bus_we,
    output logic             busy,
    output logic             done
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_NEXT = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]       state_reg;
    logic [31:0]      src_row_reg, dst_row_reg, src_ptr_reg, dst_ptr_reg;
    logic [DIM_W-1:0] col_reg, row_reg, w_reg, h_reg;
    logic [15:0]      ss_reg, ds_reg;
    logic [1:0]       rd_cnt_reg;
    logic             bus_req_reg, bus_we_reg, busy_reg, done_reg;
    logic [31:0]      bus_addr_reg, wdata_reg;

    logic             last_col, last_row, keyed;
    logic [31:0]      src_row_next, dst_row_next, src_adv, dst_adv;

    always_comb begin
        last_col     = (col_reg == w_reg - DIM_W'(1));
        last_row     = (row_reg == h_reg - DIM_W'(1));
        src_row_next = src_row_reg + {14'd0, ss_reg, 2'b00};
        dst_row_next = dst_row_reg + {14'd0, ds_reg, 2'b00};
        src_adv      = last_col ? src_row_next : src_ptr_reg + 32'd4;
        dst_adv      = last_col ? dst_row_next : dst_ptr_reg + 32'd4;
    end

`ifdef BLIT_COLORKEY_EN
    logic [11:0] key_reg;
    // Decided on the word being captured so the write strobe is correct on WR entry.
    assign keyed = (bus_rdata[11:0] == key_reg);
`else
    logic key_unused;
    assign key_unused = ^key_color;
    assign keyed      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            src_row_reg  <= '0;
            dst_row_reg  <= '0;
            src_ptr_reg  <= '0;
            dst_ptr_reg  <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            w_reg        <= '0;
            h_reg        <= '0;
            ss_reg       <= '0;
            ds_reg       <= '0;
            rd_cnt_reg   <= '0;
            bus_req_reg  <= 1'b0;
            bus_we_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            bus_addr_reg <= '0;
            wdata_reg    <= '0;
`ifdef BLIT_COLORKEY_EN
            key_reg      <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        src_row_reg <= {src_base[31:2], 2'b00};
                        src_ptr_reg <= {src_base[31:2], 2'b00};
                        dst_row_reg <= {dst_base[31:2], 2'b00};
                        dst_ptr_reg <= {dst_base[31:2], 2'b00};
                        w_reg       <= blk_w;
                        h_reg       <= blk_h;
                        ss_reg      <= src_stride;
                        ds_reg      <= dst_stride;
                        col_reg     <= '0;
                        row_reg     <= '0;
                        busy_reg    <= 1'b1;
`ifdef BLIT_COLORKEY_EN
                        key_reg     <= key_color;
`endif
                        if (blk_w == '0 || blk_h == '0) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            bus_req_reg <= 1'b1;
                            state_reg   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_grant) begin
                        state_reg    <= S_RD;
                        bus_addr_reg <= src_ptr_reg;
                        rd_cnt_reg   <= '0;
                    end
                end
                S_RD: begin
                    // Losing the grant or a stall restarts the latency count on the same address.
                    if (!bus_grant) begin
                        state_reg  <= S_REQ;
                        rd_cnt_reg <= '0;
                    end else if (!bus_ready) begin
                        rd_cnt_reg <= '0;
                    end else if (rd_cnt_reg == 2'(RD_LAT - 1)) begin
                        wdata_reg    <= bus_rdata;
                        bus_addr_reg <= dst_ptr_reg;
                        bus_we_reg   <= !keyed;
                        state_reg    <= S_WR;
                    end else begin
                        rd_cnt_reg <= rd_cnt_reg + 2'd1;
                    end
                end
                S_WR: begin
                    if (bus_ready && bus_grant) begin
                        bus_we_reg <= 1'b0;
                        state_reg  <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (last_col && last_row) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        src_ptr_reg <= src_adv;
                        dst_ptr_reg <= dst_adv;
                        if (last_col) begin
                            col_reg     <= '0;
                            row_reg     <= row_reg + DIM_W'(1);
                            src_row_reg <= src_row_next;
                            dst_row_reg <= dst_row_next;
                        end else begin
                            col_reg <= col_reg + DIM_W'(1);
                        end
                        if (bus_grant) begin
                            state_reg    <= S_RD;
                            bus_addr_reg <= src_adv;
                            rd_cnt_reg   <= '0;
                        end else begin
                            state_reg <= S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    bus_req_reg <= 1'b0;
                    busy_reg    <= 1'b0;
                    state_reg   <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus_req   = bus_req_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = wdata_reg;
    assign bus_we    = bus_we_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
endmodule

// File: tb/tb_bus_blitter.sv
// Bench for bus_blitter: ROM-like source function, logged writes, rectangle model computed from row/column arithmetic.
module tb_bus_blitter;
    localparam int DIM_W = 10;
`ifdef BLIT_COLORKEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif
    localparam logic [11:0] KEY = 12'hF0F;

    logic             clk, rst, start;
    logic [31:0]      src_base, dst_base;
    logic [DIM_W-1:0] blk_w, blk_h;
    logic [15:0]      src_stride, dst_stride;
    logic [11:0]      key_color;
    logic             bus_grant, bus_ready;
    logic [31:0]      bus_rdata;
    logic             bus_req, bus_we, busy, done;
    logic [31:0]      bus_addr, bus_wdata;

    bus_blitter #(.DIM_W(DIM_W), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_base(src_base), .dst_base(dst_base),
        .blk_w(blk_w), .blk_h(blk_h),
        .src_stride(src_stride), .dst_stride(dst_stride),
        .key_color(key_color),
        .bus_grant(bus_grant), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int copy_no = 0;
    logic [31:0] key_addr = 32'h0000_0001;
    int knob_stall_t = 0, knob_gdrop_t = 0, knob_ign_t = 0, knob_abort_t = 0;
    bit knob_rand = 1'b0;

    logic [31:0] log_a[$];
    logic [31:0] log_d[$];
    logic [31:0] got [logic [31:0]];

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == key_addr) return 32'h0000_0F0F;
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    endfunction

    assign bus_rdata = rom(bus_addr);

    always @(posedge clk)
        if (rst && bus_we && bus_ready && bus_grant) begin
            log_a.push_back(bus_addr);
            log_d.push_back(bus_wdata);
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req"}, 32'(bus_req), 0);
        check({tag, "_addr"}, bus_addr, 0);
        check({tag, "_wdata"}, bus_wdata, 0);
        check({tag, "_we"}, 32'(bus_we), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    task automatic clear_knobs();
        knob_stall_t = 0; knob_gdrop_t = 0; knob_ign_t = 0; knob_abort_t = 0; knob_rand = 1'b0;
    endtask

    task automatic run_copy(input logic [31:0] sb, input logic [31:0] db, input int w, input int h,
                            input int ss, input int ds, input int exp_done);
        int base, t, exp_n, n;
        bit seen_done, aborted, any_done;
        logic [31:0] sbase, dbase, sa, da, val;
        sbase = {sb[31:2], 2'b00};
        dbase = {db[31:2], 2'b00};
        base = log_a.size();
        copy_no++;
        src_base = sb; dst_base = db; blk_w = DIM_W'(w); blk_h = DIM_W'(h);
        src_stride = 16'(ss); dst_stride = 16'(ds);
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 1; seen_done = 1'b0; aborted = 1'b0;
        while (!seen_done && !aborted && t < 20000) begin
            if (t == knob_ign_t) begin
                start = 1'b1; src_base = 32'h3777_0000; dst_base = 32'h1555_0000;
                blk_w = 7; blk_h = 3; src_stride = 3; dst_stride = 9;
            end
            if (t == knob_stall_t) begin
                // Second word of row 0 is in its write phase here.
                check("stall_we0", 32'(bus_we), 1);
                bus_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick(); t++;
                    check("stall_addr", bus_addr, dbase + 32'd4);
                    check("stall_wdata", bus_wdata, rom(sbase + 32'd4));
                    check("stall_we", 32'(bus_we), 1);
                end
                bus_ready = 1'b1;
            end
            if (t == knob_gdrop_t) begin
                bus_grant = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick(); t++;
                    check("gdrop_req", 32'(bus_req), 1);
                    check("gdrop_we", 32'(bus_we), 0);
                end
                bus_grant = 1'b1;
                tick(); t++;
                check("regrant_addr", bus_addr, sbase + 32'd8);
            end
            if (t == knob_abort_t) begin
                rst = 1'b0;
                tick(); t++;
                rst = 1'b1;
                check_zero_outputs("abort");
                any_done = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    tick();
                    if (done) any_done = 1'b1;
                end
                check("abort_no_done", 32'(any_done), 0);
                aborted = 1'b1;
            end
            if (!aborted) begin
                if (knob_rand) begin
                    bus_ready = ($urandom_range(0, 3) != 0);
                    bus_grant = ($urandom_range(0, 4) != 0);
                end
                tick(); t++;
                start = 1'b0;
                if (done) seen_done = 1'b1;
            end
        end
        bus_ready = 1'b1; bus_grant = 1'b1;
        if (aborted) begin
            $display("copy %0d: %0dx%0d aborted by reset at tick %0d", copy_no, w, h, knob_abort_t);
            return;
        end
        check("done_seen", 32'(seen_done), 1);
        if (exp_done != 0) check("done_tick", t, exp_done);
        tick();
        check("idle_busy", 32'(busy), 0);
        got.delete();
        n = log_a.size() - base;
        for (int i = base; i < log_a.size(); i++) got[log_a[i]] = log_d[i];
        exp_n = 0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                sa  = sbase + 32'((r * ss + c) * 4);
                da  = dbase + 32'((r * ds + c) * 4);
                val = rom(sa);
                if (KEY_EN && val[11:0] == KEY) begin
                    check("key_skip", 32'(got.exists(da)), 0);
                end else begin
                    exp_n++;
                    check("wr_present", 32'(got.exists(da)), 1);
                    if (got.exists(da)) check("wr_data", got[da], val);
                end
            end
        check("wr_count", n, exp_n);
        $display("copy %0d: %0dx%0d src=%h dst=%h ss=%0d ds=%0d writes=%0d ticks=%0d",
                 copy_no, w, h, sb, db, ss, ds, n, t);
    endtask

    initial begin
        int w, h, ss, ds, busy_cnt, done_cnt;
        bit req_seen;
        rst = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; blk_w = '0; blk_h = '0;
        src_stride = '0; dst_stride = '0; key_color = KEY; bus_grant = 1'b1; bus_ready = 1'b1;
        tick(); tick();
        check_zero_outputs("reset");
        rst = 1'b1;
        tick();

        run_copy(32'h3000_0000, 32'h1000_0000, 4, 2, 640, 640, 26);

        key_addr = 32'h3000_0008;
        run_copy(32'h3000_0000, 32'h1000_1000, 4, 2, 640, 640, 26);
        key_addr = 32'h0000_0001;

        knob_stall_t = 6;
        run_copy(32'h3000_0000, 32'h1000_2000, 4, 2, 640, 640, 31);
        clear_knobs();

        knob_gdrop_t = 8;
        run_copy(32'h3000_0100, 32'h1000_3000, 4, 2, 640, 640, 0);
        clear_knobs();

        // Zero-height rectangle: bus never requested, single busy cycle, single done pulse.
        src_base = 32'h3000_0000; dst_base = 32'h1000_0000; blk_w = 3; blk_h = 0;
        start = 1'b1;
        busy_cnt = 0; done_cnt = 0; req_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (bus_req) req_seen = 1'b1;
        end
        check("degen_busy_cycles", busy_cnt, 1);
        check("degen_done_pulses", done_cnt, 1);
        check("degen_req", 32'(req_seen), 0);
        $display("copy degenerate: 3x0 busy=%0d done=%0d", busy_cnt, done_cnt);

        knob_ign_t = 5;
        run_copy(32'h3000_0040, 32'h1000_4000, 4, 2, 640, 640, 26);
        clear_knobs();

        knob_abort_t = 14;
        run_copy(32'h3000_0000, 32'h1000_5000, 4, 2, 640, 640, 0);
        clear_knobs();
        run_copy(32'h3000_0000, 32'h1000_6000, 4, 2, 640, 640, 26);

        run_copy(32'hFFFF_FFF8, 32'hFFFF_FFF8, 4, 2, 2, 4, 26);

        knob_rand = 1'b1;
        for (int i = 0; i < 12; i++) begin
            w  = int'($urandom_range(1, 6));
            h  = int'($urandom_range(1, 4));
            ss = int'($urandom_range(0, 20));
            ds = w + int'($urandom_range(0, 5));
            run_copy(32'h3000_0000 | ($urandom & 32'h00FF_FFFF),
                     32'h1000_0000 | ($urandom & 32'h00FF_FFFF), w, h, ss, ds, 0);
        end
        clear_knobs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bus_blitter.md
Name: bus_blitter

Overview:
- Bus initiator (master) for the MIO address-decoded bus; the other end of the CPU-to-peripheral decoder.
- Copies a rectangular block of 32-bit words from a source region to a destination region using bus reads and writes. Typical use: source ROM (0x3xxxxxxx) or data RAM (0x0xxxxxxx) into VRAM (0x1xxxxxxx).
- Shares the bus with the CPU through a request/grant handshake.
- Honours the bus ready/stall signal, which is low while VGA scan-out owns VRAM.

Parameters:
- DIM_W, 10, width of the rectangle width/height counters (max 1023 x 1023 words).
- RD_LAT, 1, read data latency in cycles (synchronous block RAM); legal values 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- src_base  in  32  byte address of the first source word; bits [1:0] ignored.
- dst_base  in  32  byte address of the first destination word; bits [1:0] ignored.
- blk_w  in  DIM_W  words per row.
- blk_h  in  DIM_W  number of rows.
- src_stride  in  16  source row pitch in words.
- dst_stride  in  16  destination row pitch in words.
- key_color  in  12  transparent colour (used only with the optional feature).
- bus_grant  in  1  arbiter grants the bus to the blitter.
- bus_ready  in  1  bus ready (MIO_ready); low means stall.
- bus_rdata  in  32  read data from the bus (Cpu_data4bus).
- bus_req  out  1  bus request to the arbiter.
- bus_addr  out  32  address driven onto the bus.
- bus_wdata  out  32  write data driven onto the bus.
- bus_we  out  1  write strobe (mem_w).
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the copy finishes.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0: bus_req, bus_addr, bus_wdata, bus_we, busy, done.
  - All counters and address registers are cleared.
  - Reset mid-transfer aborts immediately; no done pulse is produced.
- Parameter latch: on start in IDLE, latch all config inputs, set busy=1 and bus_req=1, go to REQ. Input changes after this point are ignored until the next IDLE.
- Degenerate size: start with blk_w=0 or blk_h=0 goes directly to DONE without requesting the bus. busy is high for 1 cycle, then done pulses.
- States:
  - IDLE: waiting for start.
  - REQ: wait for bus_grant=1, then go to RD.
  - RD: drive bus_addr=src_ptr, bus_we=0. Count RD_LAT cycles with bus_ready=1, then capture bus_rdata into the data register and go to WR. Any cycle with bus_ready=0 does not count, and the latency count restarts.
  - WR: drive bus_addr=dst_ptr, bus_wdata=data register, bus_we=1 for one cycle. If bus_ready=0 or bus_grant=0, hold WR with all outputs unchanged. Otherwise go to NEXT.
  - NEXT: bus_we=0 and pointers advance.
    - col < blk_w-1: col++, src_ptr+=4, dst_ptr+=4.
    - Else if row < blk_h-1: col=0, row++, src_row+=src_stride*4, dst_row+=dst_stride*4, and the pointers reload from the row bases.
    - Else go to DONE.
    - If still in the rectangle, go to RD when bus_grant=1, else REQ.
  - DONE: pulse done=1; bus_req=0, busy=0 next cycle; return to IDLE.
- Grant loss: loss of bus_grant in RD restarts the read from the same address once the grant returns.
- Output idling: outside RD/WR, bus_we=0 and bus_addr holds its last value.
- Arithmetic: pointer arithmetic is modulo 2^32 (wrap-around is allowed, with no error). Strides are unsigned. A stride smaller than blk_w is legal (rows overlap).
- Throughput: with grant and ready always high and RD_LAT=1, one word takes 3 cycles (RD, WR, NEXT).
- start while busy is ignored.

Optional Feature:
- Macro: BLIT_COLORKEY_EN.
- Defined: in WR, if data register[11:0]==key_color, bus_we stays 0 for that cycle. The pointers still advance and the pixel is skipped.
- Undefined: key_color is unused and every word is written.

Test Plan:
- Basic copy: src_base=0x30000000, dst_base=0x10000000, blk_w=4, blk_h=2, strides 640, grant and ready held 1 → 8 writes, to 0x10000000..0x1000000C and 0x10000A00..0x10000A0C, data equal to the source words. done pulses at cycle 1+1+8*3.
- Stall: assert bus_ready=0 for 5 cycles during the 2nd WR → bus_addr, bus_wdata and bus_we=1 held for the stall; no duplicate or missing writes; total time +5 cycles.
- Grant loss: drop bus_grant during RD of word 3 → bus_req stays 1; read reissued at the same address after the grant returns; final destination contents correct.
- Degenerate and ignored start: blk_h=0 → no bus_req, busy high 1 cycle, done pulse. A second start while busy → ignored.
- Reset mid-copy: rst=0 during the 5th word → next cycle all outputs 0 and IDLE; no done pulse; a new start works normally.
- Colour key (with BLIT_COLORKEY_EN): key_color=0xF0F, source contains 0x00000F0F at word 2 → that destination word is not written; the others are written.
